// File: rtl/blake2s_block_buf_pkg.sv
// Shared constants, state encoding and byte-placement helpers for the BLAKE2s
// message block buffer.
package blake2s_pkg;

   localparam int BB  = 64;   // block size in bytes
   localparam int W   = 32;   // message word width
   localparam int T_W = 64;   // byte counter width

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // message word holding byte position idx
   function automatic logic [3:0] word_of(input logic [5:0] idx);
      return idx[5:2];
   endfunction

   // little-endian byte lane inside that word
   function automatic logic [1:0] lane_of(input logic [5:0] idx);
      return idx[1:0];
   endfunction

   // bit offset of byte position idx inside the 512-bit block
   function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
      return 9'(word_of(idx)) * 9'(W) + 9'(lane_of(idx)) * 9'd8;
   endfunction

endpackage

// File: rtl/blake2s_block_buf_if.sv
// Byte stream in, block handshake out. The buffer takes the slave side; the
// host/core environment takes the master side.
interface blake2s_block_buf_if;
   import blake2s_pkg::*;

   logic              data_v_i;
   logic [7:0]        data_i;
   logic [5:0]        data_idx_i;
   logic              block_first_i;
   logic              block_last_i;
   logic [T_W-1:0]    ll_i;
   logic              ready_v_o;
   logic              blk_v_o;
   logic              blk_ready_i;
   logic [BB*8-1:0]   m_o;
   logic [T_W-1:0]    t_o;
   logic              first_o;
   logic              last_o;
   logic              ovf_o;

   modport slave (
      input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i,
      input  blk_ready_i,
      output ready_v_o, blk_v_o, m_o, t_o, first_o, last_o, ovf_o
   );

   modport master (
      output data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i,
      output blk_ready_i,
      input  ready_v_o, blk_v_o, m_o, t_o, first_o, last_o, ovf_o
   );

endinterface

// File: rtl/blake2s_block_buf_t_counter.sv
// BLAKE2s byte counter: running t_acc plus the per-block t value. A first
// block restarts the count, a last block reports the exact message length.
module blake2s_t_counter
   import blake2s_pkg::*;
(
   input  logic           clk,
   input  logic           nreset,
   input  logic           load,
   input  logic           first,
   input  logic           last,
   input  logic [T_W-1:0] ll,
   output logic [T_W-1:0] t
);

   logic [T_W-1:0] t_acc;
   logic [T_W-1:0] base;
   logic [T_W-1:0] sum;

   assign base = first ? '0 : t_acc;
   assign sum  = base + T_W'(BB);   // wraps modulo 2^64

   // update counter when a block completes
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         t_acc <= '0;
         t     <= '0;
      end else if (load) begin
         if (last) begin
            t <= ll;
         end else begin
            t     <= sum;
            t_acc <= sum;
         end
      end
   end

endmodule

// File: rtl/blake2s_block_buf.sv
// BLAKE2s message block buffer: assembles 64 indexed bytes into sixteen
// little-endian words and offers the block to the compression core.
// Optional macro BLAKE2S_BLOCK_BUF_ZERO_PAD_EN: zero the tail lanes of a last
// block beyond the message length, so the host may send any padding.
//
// state | meaning
// FILL  | accepting bytes; byte at index 63 closes the block
// FULL  | block offered to core; incoming bytes dropped and flagged
module blake2s_block_buf
   import blake2s_pkg::*;
(
   input  logic              clk,
   input  logic              nreset,
   blake2s_block_buf_if.slave bus
);

   state_t            state;
   logic [BB*8-1:0]   m_q;
   logic [BB*8-1:0]   m_nxt;
   logic              blk_v_q;
   logic              ready_q;
   logic              first_q;
   logic              last_q;
   logic              ovf_q;
   logic              done;
   logic [T_W-1:0]    t_q;

   assign done = (state == FILL) && bus.data_v_i && (bus.data_idx_i == 6'd63);

   // next block contents: place the incoming byte, then pad the tail of a last block
   always_comb begin
      m_nxt = m_q;
      if ((state == FILL) && bus.data_v_i)
         m_nxt[byte_lsb(bus.data_idx_i) +: 8] = bus.data_i;
`ifdef BLAKE2S_BLOCK_BUF_ZERO_PAD_EN
      // a nonzero length that is a multiple of 64 fills the last block completely
      if (done && bus.block_last_i &&
          !((bus.ll_i[5:0] == 6'd0) && (bus.ll_i != '0))) begin
         for (int b = 0; b < BB; b++) begin
            if (7'(b) >= {1'b0, bus.ll_i[5:0]})
               m_nxt[b*8 +: 8] = 8'h00;
         end
      end
`endif
   end

   // fill/full sequencing with registered handshake outputs
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= FILL;
         m_q     <= '0;
         blk_v_q <= 1'b0;
         ready_q <= 1'b1;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               m_q <= m_nxt;
               if (done) begin
                  state   <= FULL;
                  blk_v_q <= 1'b1;
                  ready_q <= 1'b0;
                  first_q <= bus.block_first_i;
                  last_q  <= bus.block_last_i;
               end
            end
            FULL: begin
               if (bus.data_v_i)
                  ovf_q <= 1'b1;
               if (blk_v_q && bus.blk_ready_i) begin
                  state   <= FILL;
                  blk_v_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   blake2s_t_counter u_t_counter (
      .clk    (clk),
      .nreset (nreset),
      .load   (done),
      .first  (bus.block_first_i),
      .last   (bus.block_last_i),
      .ll     (bus.ll_i),
      .t      (t_q)
   );

   assign bus.m_o       = m_q;
   assign bus.t_o       = t_q;
   assign bus.blk_v_o   = blk_v_q;
   assign bus.ready_v_o = ready_q;
   assign bus.first_o   = first_q;
   assign bus.last_o    = last_q;
   assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_blake2s_block_buf.sv
// Bench for blake2s_block_buf: table of block vectors plus hand sequences for
// back-pressure/overflow, mid-block reset and out-of-order indices.
module tb_blake2s_block_buf;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   blake2s_block_buf_if bus();

   blake2s_block_buf dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

`ifdef BLAKE2S_BLOCK_BUF_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   typedef struct {
      logic [511:0] m;
      logic [63:0]  t;
      logic         first;
      logic         last;
   } blk_t;

   typedef struct {
      int          pat;
      logic [7:0]  seed;
      logic [63:0] ll;
      logic        first;
      logic        last;
      logic [63:0] t;
      bit          shuf;
      bit          gaps;
      int          hold;
   } vec_t;

   blk_t sb[$];
   vec_t vecs[11];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] byte_val(input int pat, input logic [7:0] seed, input int b);
      case (pat)
         0:       return (b < 3) ? 8'(8'h61 + b) : 8'h00;
         1:       return seed ^ 8'(b * 37);
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [511:0] exp_m(input int pat, input logic [7:0] seed,
                                          input logic last, input logic [63:0] ll);
      logic [511:0] m;
      logic [7:0]   v;
      int           tail;
      tail = int'(ll[5:0]);
      m = '0;
      for (int b = 0; b < 64; b++) begin
         v = byte_val(pat, seed, b);
         if (PAD_EN && last && !(tail == 0 && ll != 0) && b >= tail)
            v = 8'h00;
         m[b*8 +: 8] = v;
      end
      return m;
   endfunction

   task automatic drive_byte(input int idx, input logic [7:0] val, input logic first, input logic last);
      @(negedge clk);
      bus.data_v_i      = 1'b1;
      bus.data_idx_i    = 6'(idx);
      bus.data_i        = val;
      bus.block_first_i = first;
      bus.block_last_i  = last;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.data_v_i = 1'b0;
   endtask

   task automatic send_block(input string name, input int pat, input logic [7:0] seed,
                             input logic [63:0] ll, input logic first, input logic last,
                             input logic [63:0] t, input bit shuf, input bit gaps);
      int   ord[64];
      int   j, tmp;
      logic early;
      blk_t e;
      for (int i = 0; i < 64; i++) ord[i] = i;
      if (shuf) begin
         for (int i = 62; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
      end
      bus.ll_i = ll;
      e.m = exp_m(pat, seed, last, ll);
      e.t = t;
      e.first = first;
      e.last = last;
      sb.push_back(e);
      early = 1'b0;
      for (int i = 0; i < 64; i++) begin
         drive_byte(ord[i], byte_val(pat, seed, ord[i]), first, last);
         early |= bus.blk_v_o;
         if (gaps && i < 63 && $urandom_range(0, 2) == 0) begin
            idle();
            early |= bus.blk_v_o;
         end
      end
      @(negedge clk);
      chk({name, ".early_blk_v"}, early, 1'b0);
      chk({name, ".latency_blk_v"}, bus.blk_v_o, 1'b1);
      chk({name, ".ready_low"}, bus.ready_v_o, 1'b0);
      bus.data_v_i = 1'b0;
   endtask

   task automatic recv_block(input string name, input int hold);
      int   n;
      logic unstable;
      blk_t e;
      n = 0;
      while (!bus.blk_v_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, ".blk_v_timeout"}, bus.blk_v_o, 1'b1);
      chk({name, ".sb_nonempty"}, (sb.size() > 0), 1'b1);
      if (!bus.blk_v_o || sb.size() == 0) return;
      e = sb.pop_front();
      unstable = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (bus.m_o !== e.m || bus.blk_v_o !== 1'b1 || bus.ready_v_o !== 1'b0) unstable = 1'b1;
      end
      chk({name, ".hold_stable"}, unstable, 1'b0);
      chk({name, ".m"}, bus.m_o, e.m);
      chk({name, ".t"}, bus.t_o, e.t);
      chk({name, ".first"}, bus.first_o, e.first);
      chk({name, ".last"}, bus.last_o, e.last);
      bus.blk_ready_i = 1'b1;
      @(negedge clk);
      bus.blk_ready_i = 1'b0;
      chk({name, ".blk_v_drop"}, bus.blk_v_o, 1'b0);
      chk({name, ".ready_back"}, bus.ready_v_o, 1'b1);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, ".m"}, bus.m_o, '0);
      chk({name, ".t"}, bus.t_o, '0);
      chk({name, ".blk_v"}, bus.blk_v_o, 1'b0);
      chk({name, ".first"}, bus.first_o, 1'b0);
      chk({name, ".last"}, bus.last_o, 1'b0);
      chk({name, ".ovf"}, bus.ovf_o, 1'b0);
      chk({name, ".ready"}, bus.ready_v_o, 1'b1);
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      blk_t         e;
      logic         unstable;
      logic [511:0] m_before;

      //                pat seed   ll                       first last t                        shuf gaps hold
      vecs[0]  = '{0, 8'h00, 64'd3,                    1'b1, 1'b1, 64'd3,                    1'b0, 1'b0, 0};
      vecs[1]  = '{1, 8'h11, 64'd100,                  1'b1, 1'b0, 64'd64,                   1'b0, 1'b1, 2};
      vecs[2]  = '{1, 8'h22, 64'd100,                  1'b0, 1'b1, 64'd100,                  1'b1, 1'b0, 0};
      vecs[3]  = '{1, 8'h33, 64'd200,                  1'b1, 1'b0, 64'd64,                   1'b1, 1'b1, 1};
      vecs[4]  = '{1, 8'h44, 64'd200,                  1'b0, 1'b0, 64'd128,                  1'b0, 1'b0, 0};
      vecs[5]  = '{1, 8'h55, 64'd200,                  1'b0, 1'b1, 64'd200,                  1'b1, 1'b1, 3};
      vecs[6]  = '{1, 8'h66, 64'd0,                    1'b1, 1'b1, 64'd0,                    1'b0, 1'b0, 0};
      vecs[7]  = '{2, 8'h00, 64'd5,                    1'b1, 1'b1, 64'd5,                    1'b0, 1'b1, 0};
      vecs[8]  = '{1, 8'h77, 64'd128,                  1'b1, 1'b0, 64'd64,                   1'b1, 1'b0, 0};
      vecs[9]  = '{1, 8'h88, 64'd128,                  1'b0, 1'b1, 64'd128,                  1'b0, 1'b0, 1};
      vecs[10] = '{2, 8'h00, 64'hFFFF_FFFF_FFFF_FFC5,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC5,  1'b0, 1'b0, 0};

      nreset            = 1'b0;
      bus.data_v_i      = 1'b0;
      bus.data_i        = '0;
      bus.data_idx_i    = '0;
      bus.block_first_i = 1'b0;
      bus.block_last_i  = 1'b0;
      bus.ll_i          = '0;
      bus.blk_ready_i   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      nreset = 1'b1;

      for (int v = 0; v < 11; v++) begin
         send_block($sformatf("vec%0d", v), vecs[v].pat, vecs[v].seed, vecs[v].ll,
                    vecs[v].first, vecs[v].last, vecs[v].t, vecs[v].shuf, vecs[v].gaps);
         recv_block($sformatf("vec%0d", v), vecs[v].hold);
      end

      // back-pressure with overflow bytes while full
      send_block("bp", 1, 8'h99, 64'd1000, 1'b1, 1'b0, 64'd64, 1'b0, 1'b0);
      unstable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ready_v_o !== 1'b0 || bus.blk_v_o !== 1'b1) unstable = 1'b1;
      end
      chk("bp.wait_ready_low", unstable, 1'b0);
      for (int i = 0; i < 5; i++) drive_byte(i, 8'hA5, 1'b0, 1'b0);
      idle();
      chk("bp.ovf_set", bus.ovf_o, 1'b1);
      chk("bp.m_unchanged", bus.m_o, sb[0].m);
      chk("bp.ready_still_low", bus.ready_v_o, 1'b0);
      recv_block("bp", 0);
      chk("bp.ovf_sticky", bus.ovf_o, 1'b1);

      // reset after 20 bytes of a block
      bus.ll_i = 64'd1000;
      for (int i = 0; i < 20; i++) drive_byte(i, 8'hC3, 1'b0, 1'b0);
      idle();
      #2 nreset = 1'b0;
      #1 check_reset_values("midrst");
      @(negedge clk);
      nreset = 1'b1;
      send_block("postrst", 1, 8'h3C, 64'd1000, 1'b0, 1'b0, 64'd64, 1'b0, 1'b1);
      recv_block("postrst", 0);

      // out-of-order: idx 63 first closes the block at once
      @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      bus.ll_i = 64'd1000;
      e.m = '0;
      e.m[511:504] = 8'h5A;
      e.t = 64'd64;
      e.first = 1'b1;
      e.last = 1'b0;
      sb.push_back(e);
      drive_byte(63, 8'h5A, 1'b1, 1'b0);
      @(negedge clk);
      chk("ooo.latency_blk_v", bus.blk_v_o, 1'b1);
      m_before = bus.m_o;
      for (int i = 0; i < 63; i++) drive_byte(i, 8'h11, 1'b1, 1'b0);
      idle();
      chk("ooo.ovf_set", bus.ovf_o, 1'b1);
      chk("ooo.m_unchanged", bus.m_o, e.m);
      chk("ooo.m_stable", bus.m_o, m_before);
      recv_block("ooo", 0);

      chk("sb.drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
